// File: rtl/reg_file_rename_if.sv
// Decoder/commit-side bundle for reg_file_rename: rename, commit, flush,
// two query ports and the pending-tag count.
interface reg_file_rename_if #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4
);
    logic              ena;
    logic              in_rename_ena;
    logic [REG_W-1:0]  in_rename_reg;
    logic [ROB_W-1:0]  in_rename_tag;
    logic [REG_W-1:0]  in_commit_reg;
    logic [ROB_W-1:0]  in_commit_tag;
    logic [DATA_W-1:0] in_commit_value;
    logic              in_flush;
    logic [REG_W-1:0]  in_query_reg1;
    logic [REG_W-1:0]  in_query_reg2;
    logic [DATA_W-1:0] out_value1;
    logic [DATA_W-1:0] out_value2;
    logic [ROB_W-1:0]  out_tag1;
    logic [ROB_W-1:0]  out_tag2;
    logic [ROB_W+1:0]  out_pending;

    modport master (
        output ena, in_rename_ena, in_rename_reg, in_rename_tag,
               in_commit_reg, in_commit_tag, in_commit_value, in_flush,
               in_query_reg1, in_query_reg2,
        input  out_value1, out_value2, out_tag1, out_tag2, out_pending
    );

    modport slave (
        input  ena, in_rename_ena, in_rename_reg, in_rename_tag,
               in_commit_reg, in_commit_tag, in_commit_value, in_flush,
               in_query_reg1, in_query_reg2,
        output out_value1, out_value2, out_tag1, out_tag2, out_pending
    );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags, a commit
// bypass on both query ports, and a registered count of pending tags.
module reg_file_rename #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    reg_file_rename_if.slave   bus
);
    localparam int NREG   = 1 << REG_W;
    localparam int PEND_W = ROB_W + 2;

    logic [DATA_W-1:0] value_reg [NREG];
    logic [ROB_W-1:0]  tag_reg   [NREG];
    logic [PEND_W-1:0] pending_reg;
    logic [PEND_W-1:0] pending_next;

    logic commit_valid;
    logic commit_match;
    logic rename_valid;
    logic flush_valid;
    logic pending_inc;
    logic pending_dec;
    logic bypass1;
    logic bypass2;

    always_comb begin
        commit_valid = bus.ena && (bus.in_commit_reg != '0);
        commit_match = commit_valid && (tag_reg[bus.in_commit_reg] == bus.in_commit_tag);
        flush_valid  = bus.ena && bus.in_flush;
        rename_valid = bus.ena && bus.in_rename_ena && !bus.in_flush && (bus.in_rename_reg != '0);
        pending_inc  = rename_valid && (tag_reg[bus.in_rename_reg] == '0);
        // A release only counts when a live tag goes away and no rename re-tags the register.
        pending_dec  = commit_match && (tag_reg[bus.in_commit_reg] != '0) &&
                       !(rename_valid && (bus.in_rename_reg == bus.in_commit_reg));
        if (flush_valid) begin
            pending_next = '0;
        end else begin
            pending_next = pending_reg + {{(PEND_W-1){1'b0}}, pending_inc}
                                       - {{(PEND_W-1){1'b0}}, pending_dec};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                value_reg[i] <= '0;
                tag_reg[i]   <= '0;
            end
            pending_reg <= '0;
        end else begin
            value_reg[0] <= '0;
            tag_reg[0]   <= '0;
            if (commit_valid) begin
                value_reg[bus.in_commit_reg] <= bus.in_commit_value;
            end
            if (flush_valid) begin
                for (int i = 1; i < NREG; i++) begin
                    tag_reg[i] <= '0;
                end
            end else begin
                if (commit_match) begin
                    tag_reg[bus.in_commit_reg] <= '0;
                end
                // Ordered after the clear so a same-register rename wins.
                if (rename_valid) begin
                    tag_reg[bus.in_rename_reg] <= bus.in_rename_tag;
                end
            end
            if (bus.ena) begin
                pending_reg <= pending_next;
            end
        end
    end

    always_comb begin
        bypass1 = commit_match && (bus.in_commit_reg == bus.in_query_reg1);
        bypass2 = commit_match && (bus.in_commit_reg == bus.in_query_reg2);
        bus.out_value1  = bypass1 ? bus.in_commit_value : value_reg[bus.in_query_reg1];
        bus.out_tag1    = bypass1 ? '0 : tag_reg[bus.in_query_reg1];
        bus.out_value2  = bypass2 ? bus.in_commit_value : value_reg[bus.in_query_reg2];
        bus.out_tag2    = bypass2 ? '0 : tag_reg[bus.in_query_reg2];
        bus.out_pending = pending_reg;
    end
endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares against the query outputs.
module tb_reg_file_rename;
    logic clk;
    logic rst;

    reg_file_rename_if #(.REG_W(5), .DATA_W(32), .ROB_W(4)) bus ();

    reg_file_rename #(.REG_W(5), .DATA_W(32), .ROB_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] v1;
        logic [3:0]  t1;
        logic [31:0] v2;
        logic [3:0]  t2;
        logic [5:0]  pend;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.out_value1 !== e.v1 || bus.out_tag1 !== e.t1 ||
                bus.out_value2 !== e.v2 || bus.out_tag2 !== e.t2 ||
                bus.out_pending !== e.pend) begin
                errors++;
                $display("FAIL %s: got v1=%h t1=%0d v2=%h t2=%0d pend=%0d, want v1=%h t1=%0d v2=%h t2=%0d pend=%0d",
                         e.name, bus.out_value1, bus.out_tag1, bus.out_value2, bus.out_tag2,
                         bus.out_pending, e.v1, e.t1, e.v2, e.t2, e.pend);
            end else begin
                $display("ok   %s: v1=%h t1=%0d v2=%h t2=%0d pend=%0d",
                         e.name, e.v1, e.t1, e.v2, e.t2, e.pend);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic ren, input logic [4:0] rreg,
                         input logic [3:0] rtag, input logic [4:0] creg,
                         input logic [3:0] ctag, input logic [31:0] cval,
                         input logic fl);
        bus.ena             = e;
        bus.in_rename_ena   = ren;
        bus.in_rename_reg   = rreg;
        bus.in_rename_tag   = rtag;
        bus.in_commit_reg   = creg;
        bus.in_commit_tag   = ctag;
        bus.in_commit_value = cval;
        bus.in_flush        = fl;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 5'd0, 4'd0, 5'd0, 4'd0, 32'h0, 1'b0);
    endtask

    task automatic expect_q(input string name, input logic [4:0] q1, input logic [4:0] q2,
                            input logic [31:0] v1, input logic [3:0] t1,
                            input logic [31:0] v2, input logic [3:0] t2,
                            input logic [5:0] p);
        exp_t e;
        bus.in_query_reg1 = q1;
        bus.in_query_reg2 = q2;
        e.name = name; e.v1 = v1; e.t1 = t1; e.v2 = v2; e.t2 = t2; e.pend = p;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.in_query_reg1 = 5'd0;
        bus.in_query_reg2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and x0 write discard
        expect_q("reset_x5_x0", 5'd5, 5'd0, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);
        next_cycle(); drive(1'b1, 1'b0, 5'd0, 4'd0, 5'd0, 4'd0, 32'hDEAD, 1'b0);
        expect_q("x0_commit_same", 5'd0, 5'd0, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);
        next_cycle(); idle();
        expect_q("x0_after", 5'd0, 5'd5, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);

        // Rename then matching commit with bypass
        next_cycle(); drive(1'b1, 1'b1, 5'd3, 4'd2, 5'd0, 4'd0, 32'h0, 1'b0);
        expect_q("rename_not_visible", 5'd3, 5'd3, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);
        next_cycle(); idle();
        expect_q("x3_tag2", 5'd3, 5'd0, 32'h0, 4'd2, 32'h0, 4'd0, 6'd1);
        next_cycle(); drive(1'b1, 1'b0, 5'd0, 4'd0, 5'd3, 4'd2, 32'h1234, 1'b0);
        expect_q("x3_bypass", 5'd3, 5'd3, 32'h1234, 4'd0, 32'h1234, 4'd0, 6'd1);
        next_cycle(); idle();
        expect_q("x3_stored", 5'd3, 5'd0, 32'h1234, 4'd0, 32'h0, 4'd0, 6'd0);

        // Stale commit keeps the younger tag
        next_cycle(); drive(1'b1, 1'b1, 5'd3, 4'd2, 5'd0, 4'd0, 32'h0, 1'b0);
        next_cycle(); drive(1'b1, 1'b1, 5'd3, 4'd5, 5'd0, 4'd0, 32'h0, 1'b0);
        expect_q("x3_retag_old", 5'd3, 5'd0, 32'h1234, 4'd2, 32'h0, 4'd0, 6'd1);
        next_cycle(); drive(1'b1, 1'b0, 5'd0, 4'd0, 5'd3, 4'd2, 32'h11, 1'b0);
        expect_q("stale_no_bypass", 5'd3, 5'd0, 32'h1234, 4'd5, 32'h0, 4'd0, 6'd1);
        next_cycle(); idle();
        expect_q("stale_value", 5'd3, 5'd0, 32'h11, 4'd5, 32'h0, 4'd0, 6'd1);
        next_cycle(); drive(1'b1, 1'b0, 5'd0, 4'd0, 5'd3, 4'd5, 32'h22, 1'b0);
        expect_q("young_bypass", 5'd3, 5'd0, 32'h22, 4'd0, 32'h0, 4'd0, 6'd1);
        next_cycle(); idle();
        expect_q("young_stored", 5'd3, 5'd0, 32'h22, 4'd0, 32'h0, 4'd0, 6'd0);

        // Same-cycle commit and rename on x7
        next_cycle(); drive(1'b1, 1'b1, 5'd7, 4'd4, 5'd0, 4'd0, 32'h0, 1'b0);
        next_cycle(); drive(1'b1, 1'b1, 5'd7, 4'd6, 5'd7, 4'd4, 32'h99, 1'b0);
        expect_q("x7_collide_bypass", 5'd7, 5'd0, 32'h99, 4'd0, 32'h0, 4'd0, 6'd1);
        next_cycle(); idle();
        expect_q("x7_collide_after", 5'd7, 5'd0, 32'h99, 4'd6, 32'h0, 4'd0, 6'd1);

        // Flush with simultaneous commit and rename
        next_cycle(); drive(1'b1, 1'b1, 5'd1, 4'd1, 5'd0, 4'd0, 32'h0, 1'b0);
        next_cycle(); drive(1'b1, 1'b1, 5'd2, 4'd2, 5'd0, 4'd0, 32'h0, 1'b0);
        next_cycle(); drive(1'b1, 1'b1, 5'd3, 4'd3, 5'd0, 4'd0, 32'h0, 1'b0);
        next_cycle(); drive(1'b1, 1'b1, 5'd5, 4'd9, 5'd2, 4'd2, 32'hAB, 1'b1);
        expect_q("flush_cycle", 5'd2, 5'd3, 32'hAB, 4'd0, 32'h22, 4'd3, 6'd4);
        next_cycle(); idle();
        expect_q("flush_after", 5'd2, 5'd3, 32'hAB, 4'd0, 32'h22, 4'd0, 6'd0);
        next_cycle(); idle();
        expect_q("flush_rename_drop", 5'd5, 5'd7, 32'h0, 4'd0, 32'h99, 4'd0, 6'd0);

        // ena low holds all state and disables the bypass
        next_cycle(); drive(1'b1, 1'b1, 5'd4, 4'd7, 5'd0, 4'd0, 32'h0, 1'b0);
        next_cycle(); drive(1'b0, 1'b1, 5'd4, 4'd8, 5'd4, 4'd7, 32'h55, 1'b1);
        expect_q("ena_low_cycle", 5'd4, 5'd4, 32'h0, 4'd7, 32'h0, 4'd7, 6'd1);
        next_cycle(); drive(1'b0, 1'b0, 5'd0, 4'd0, 5'd0, 4'd0, 32'h0, 1'b0);
        expect_q("ena_low_hold", 5'd4, 5'd0, 32'h0, 4'd7, 32'h0, 4'd0, 6'd1);
        next_cycle(); idle();
        expect_q("ena_restored", 5'd4, 5'd0, 32'h0, 4'd7, 32'h0, 4'd0, 6'd1);

        // Asynchronous reset mid-cycle
        next_cycle(); drive(1'b1, 1'b1, 5'd6, 4'd3, 5'd0, 4'd0, 32'h0, 1'b0);
        next_cycle(); idle();
        bus.in_query_reg1 = 5'd4;
        bus.in_query_reg2 = 5'd6;
        #1;
        rst = 1'b1;
        expect_q("async_reset", 5'd4, 5'd6, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);
        next_cycle(); rst = 1'b0; idle();
        expect_q("post_reset", 5'd6, 5'd7, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_rename.md
# reg_file_rename

Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer's commit port and upstream of the decoder's operand fetch. The decoder marks each destination register with the ROB tag of its producer. ROB commits write values back and release a tag only when it still matches. A misbranch flush drops every pending tag so operands read back as committed state.

## Interface
Parameters:
- REG_W, 5, register index width (32 registers; x0 hard-wired to 0)
- DATA_W, 32, data width
- ROB_W, 4, ROB tag width; tag 0 means "no producer / value valid"

Ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  global enable; low = hold all state, ignore rename/commit/flush
- in_rename_ena  in  1  decoder assigns a new producer this cycle
- in_rename_reg  in  REG_W  destination register of renamed instruction
- in_rename_tag  in  ROB_W  ROB tag of the producer (nonzero)
- in_commit_reg  in  REG_W  committed destination; 0 = no commit this cycle
- in_commit_tag  in  ROB_W  ROB tag of committing entry
- in_commit_value  in  DATA_W  committed result
- in_flush  in  1  misbranch: discard all speculative tags
- in_query_reg1 / in_query_reg2  in  REG_W  decoder source operands
- out_value1 / out_value2  out  DATA_W  combinational register value
- out_tag1 / out_tag2  out  ROB_W  combinational pending tag, 0 if value is final
- out_pending  out  ROB_W+2  registered count of registers holding a nonzero tag

## Operation
- State: value[1..31], tag[1..31]. Index 0 reads value 0, tag 0. Writes to index 0 are discarded.
- Commit (in_commit_reg != 0):
  - value[r] <= in_commit_value unconditionally.
  - tag[r] <= 0 only if tag[r] == in_commit_tag. Otherwise a younger producer still owns r and its tag stays.
- Rename (in_rename_ena, reg != 0): tag[r] <= in_rename_tag. Value is untouched.
- Same register, same cycle:
  - Rename has priority over the commit's tag clear; the new tag survives.
  - The commit's value write still happens.
- Flush: every tag <= 0, and out_pending <= 0.
  - A same-cycle commit value write still happens.
  - A same-cycle rename is ignored.
- Query path (combinational):
  - Default: out_value = value[q], out_tag = tag[q].
  - Same-cycle bypass: if a commit is valid, in_commit_reg == q != 0 and tag[q] == in_commit_tag, then out_value = in_commit_value and out_tag = 0.
  - A rename in the same cycle is not visible to the query; it takes effect from the next cycle.
- out_pending tracks the number of r in 1..31 with tag[r] != 0. Next value equals current value:
  - plus 1 for a rename of a currently untagged register,
  - minus 1 for a commit that clears a tag without a same-register rename.
  - Rename and commit on the same register leave it unchanged. Range 0..31; no wrap.
- ena low: no state changes. Queries still answer combinationally from held state, with the bypass disabled.

## Timing
- Reset (asynchronous, immediate): all values 0, all tags 0, out_pending 0. Query outputs then read 0/0.
- Rename at edge N: out_tag for that register is the new tag from cycle N+1.
- Commit at edge N: value visible via the bypass during cycle N and from storage from cycle N+1.
- Flush at edge N: all out_tag = 0 from cycle N+1.
- Reset asserted mid-operation overrides everything in that cycle. There is no partial update.
- No handshake and no backpressure; every input is sampled each enabled cycle.

## Test plan
- Reset, then query x5 and x0 -> value 0, tag 0, out_pending 0. Commit to x0 with value 0xDEAD -> x0 still reads 0.
- Rename x3 with tag 2. Next cycle query x3 -> tag 2, out_pending 1. Commit x3/tag 2/0x1234 -> bypass shows 0x1234 and tag 0 in the same cycle; stored thereafter, out_pending 0.
- Rename x3 tag 2, then rename x3 tag 5, then commit x3/tag 2/0x11 -> value 0x11, tag stays 5, out_pending 1. Commit tag 5/0x22 -> tag 0, value 0x22.
- Same cycle: commit x7/tag 4/0x99 (tag[x7]=4) and rename x7 tag 6 -> next cycle value 0x99, tag 6, out_pending unchanged.
- Rename x1, x2, x3 with tags 1, 2, 3, then flush with a simultaneous commit x2/tag 2/0xAB -> all tags 0, x2 = 0xAB, out_pending 0. A rename in the flush cycle leaves no tag.
- ena low with rename, commit and flush driven -> no state change. Assert rst mid-sequence -> all outputs 0 immediately, before the next clock edge.
